// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: serialises bytes from a small input FIFO as 8N1 frames
// (start 0, 8 data bits LSB first, stop 1). Queued bytes leave back-to-back
// with no idle gap between frames.
//
// Optional build macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit is inserted between the data bits and the
//                stop bit (frame = 11 bit periods)
//   undefined -> plain 8N1 (frame = 10 bit periods)
//
// Parameters:
//   CLK_FREQ   fabric clock in Hz
//   BAUD_RATE  line rate in bit/s; bit period = CLK_FREQ / BAUD_RATE cycles
//   FIFO_DEPTH input FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk         fabric clock, rising edge
//   reset       synchronous active-high reset
//   tx_data     byte offered by the producer
//   tx_valid    producer offers tx_data this cycle
//   tx_ready    FIFO can accept (write on tx_valid && tx_ready)
//   tx_serial   registered UART line, idle high
//   tx_busy     frame in progress, start through stop
//   tx_done     one-cycle pulse on the last cycle of each stop bit
//   fifo_count  bytes queued and not yet started
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = $clog2(BAUD_TICKS) + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_TICKS - 1);
  localparam logic [PTR_W:0]   FULL      = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  // FIFO storage and control
  logic [7:0]       r_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  // Frame engine
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_serial;
  logic             r_busy;
`ifdef UART_TX_PARITY_EN
  logic             r_parity;
`endif

  logic       w_push;
  logic       w_pop;
  logic       w_empty;
  logic       w_bit_end;
  logic [7:0] w_head;

  assign w_empty   = (r_count == '0);
  assign w_bit_end = (r_baud == BAUD_LAST);
  assign w_head    = r_mem[r_rptr];

  // A pop happens either from idle or on the last stop cycle, so a queued
  // byte starts on the very next cycle with no idle gap.
  assign w_pop  = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  assign tx_ready = (r_count != FULL) && !reset;
  assign w_push   = tx_valid && tx_ready;

  assign tx_serial  = r_serial;
  assign tx_busy    = r_busy;
  assign tx_done    = (r_state == S_STOP) && w_bit_end;
  assign fifo_count = r_count;

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Datapath registers: FIFO storage and the shift register. The shift
  // register is loaded at pop, so producer activity cannot disturb a frame.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
    if (w_pop) begin
      r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
      r_parity <= ^w_head;
`endif
    end else if ((r_state == S_DATA) && w_bit_end) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  // Frame state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_serial <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (!w_empty) begin
            r_serial <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud   <= '0;
            r_bit    <= '0;
            r_serial <= r_shift[0];
            r_state  <= S_DATA;
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_serial <= r_parity;
              r_state  <= S_PARITY;
`else
              r_serial <= 1'b1;
              r_state  <= S_STOP;
`endif
            end else begin
              // r_shift[0] is the bit on the line now; [1] is the next one.
              r_bit    <= r_bit + 3'd1;
              r_serial <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud   <= '0;
            r_serial <= 1'b1;
            r_state  <= S_STOP;
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            r_bit  <= '0;
            if (!w_empty) begin
              r_serial <= 1'b0;
              r_state  <= S_START;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_baud   <= '0;
          r_bit    <= '0;
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Directed testbench for uart_tx. The DUT runs at CLK_FREQ=1_000_000,
// BAUD_RATE=115200, so a bit period is 1_000_000/115200 = 8 cycles (integer
// divide) and a frame is 80 cycles (88 with UART_TX_PARITY_EN).
// A line monitor decodes frames and checks bit-period stability and tx_done
// placement; the initial block drives the steps and asserts expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int TK = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * TK;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (115200),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .fifo_count(fifo_count)
  );

  int n_chk = 0;
  int n_err = 0;

  // Line monitor state
  int         gcyc = 0;
  int         mcyc = 0;
  int         mstamp = 0;
  int         mgl = 0;
  int         mbi, mti;
  bit         mact = 1'b0;
  bit         mexp;
  int         done_err = 0;
  int         done_cnt = 0;
  logic       lvl [0:NB-1];
  logic [7:0] md;
  logic [7:0] q_data [$];
  int         q_start[$];
  bit         q_stop [$];
  int         q_gl   [$];
`ifdef UART_TX_PARITY_EN
  bit         q_par  [$];
`endif

  always @(negedge clk) begin
    gcyc++;
    if (tx_done === 1'b1) done_cnt++;
    mexp = 1'b0;
    if (reset) begin
      mact = 1'b0;
    end else begin
      if (!mact && tx_serial === 1'b0) begin
        mact = 1'b1; mcyc = 0; mstamp = gcyc; mgl = 0;
      end
      if (mact) begin
        mbi = mcyc / TK;
        mti = mcyc % TK;
        if (mti == 0) lvl[mbi] = tx_serial;
        else if (tx_serial !== lvl[mbi]) mgl++;
        if (mbi == NB-1 && mti == TK-1) begin
          mexp = 1'b1;
          for (int i = 0; i < 8; i++) md[i] = lvl[1+i];
          q_data.push_back(md);
          q_start.push_back(mstamp);
          q_stop.push_back(lvl[NB-1] === 1'b1);
          q_gl.push_back(mgl);
`ifdef UART_TX_PARITY_EN
          q_par.push_back(lvl[9] === 1'b1);
`endif
          mact = 1'b0;
        end
        mcyc++;
      end
    end
    if (tx_done !== mexp) done_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (q_data.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("frames_seen", q_data.size(), n);
  endtask

  task automatic clear_q();
    q_data.delete(); q_start.delete(); q_stop.delete(); q_gl.delete();
`ifdef UART_TX_PARITY_EN
    q_par.delete();
`endif
  endtask

  task automatic frame_ok(input int i, input logic [7:0] d);
    chk($sformatf("data_%0d", i), q_data[i], d);
    chk($sformatf("stop_%0d", i), q_stop[i], 1);
    chk($sformatf("stable_%0d", i), q_gl[i], 0);
  endtask

  logic [7:0] exp3 [0:4];
  int t0, dc0, bad, acc;
  bit rdy;

  initial begin
    // Reset state
    step(3);
    chk("ready_in_reset", tx_ready, 0);
    chk("reset_serial", tx_serial, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_count", fifo_count, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", tx_ready, 1);
    chk("reset_done", tx_done, 0);

    // Long idle: line stays high, nothing happens
    bad = 0;
    repeat (20000) begin
      step();
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("idle_no_frames", q_data.size(), 0);
    chk("idle_no_done", done_cnt, 0);

    // Single byte 0x55 from idle
    tx_data = 8'h55; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("lat_write_edge_serial", tx_serial, 1);
    chk("lat_count_one", fifo_count, 1);
    step();
    chk("lat_start_serial", tx_serial, 0);
    chk("lat_start_busy", tx_busy, 1);
    chk("lat_popped", fifo_count, 0);
    t0 = gcyc;
    wait_frames(1, FL + 10);
    frame_ok(0, 8'h55);
    chk("f55_start_stamp", q_start[0], t0);
    chk("f55_frame_len", gcyc - t0, FL - 1);
    chk("f55_done_last", tx_done, 1);
    chk("f55_busy_last", tx_busy, 1);
    step();
    chk("f55_busy_drop", tx_busy, 0);
    chk("f55_line_idle", tx_serial, 1);
    chk("f55_done_cnt", done_cnt, 1);

    // Three back-to-back bytes
    clear_q();
    dc0 = done_cnt;
    tx_valid = 1'b1;
    tx_data = 8'hAA; step();
    tx_data = 8'h01; step();
    tx_data = 8'h02; step();
    tx_valid = 1'b0;
    chk("b2b_count", fifo_count, 2);
    wait_frames(3, 3 * FL + 10);
    frame_ok(0, 8'hAA);
    frame_ok(1, 8'h01);
    frame_ok(2, 8'h02);
    chk("b2b_gap01", q_start[1] - q_start[0], FL);
    chk("b2b_gap12", q_start[2] - q_start[1], FL);
    chk("b2b_total", gcyc - q_start[0], 3 * FL - 1);
    chk("b2b_done_cnt", done_cnt - dc0, 3);
    step();
    chk("b2b_busy_drop", tx_busy, 0);

    // Fill the FIFO while a frame is in flight
    clear_q();
    tx_data = 8'h20; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    tx_data = 8'h10; tx_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      rdy = tx_ready;
      step();
      if (rdy) begin
        acc++;
        tx_data = tx_data + 8'h01;
      end
    end
    tx_valid = 1'b0;
    chk("fill_accepted", acc, 4);
    chk("fill_count", fifo_count, 4);
    chk("fill_ready_low", tx_ready, 0);
    chk("fill_next_data", tx_data, 8'h14);
    exp3[0] = 8'h20; exp3[1] = 8'h10; exp3[2] = 8'h11; exp3[3] = 8'h12; exp3[4] = 8'h13;
    wait_frames(5, 5 * FL + 10);
    for (int i = 0; i < 5; i++) frame_ok(i, exp3[i]);
    step();
    chk("fill_busy_drop", tx_busy, 0);
    chk("fill_empty", fifo_count, 0);

    // Reset during data bit 3 with two bytes queued
    clear_q();
    dc0 = done_cnt;
    tx_data = 8'h5A; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    t0 = gcyc;
    tx_valid = 1'b1;
    tx_data = 8'h66; step();
    tx_data = 8'h77; step();
    tx_valid = 1'b0;
    chk("rst_queued", fifo_count, 2);
    while (gcyc < t0 + 4 * TK + 3) step();
    chk("rst_mid_busy", tx_busy, 1);
    reset = 1'b1;
    step();
    chk("rst_serial", tx_serial, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_flushed", fifo_count, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready", tx_ready, 1);
    bad = 0;
    repeat (3 * FL) begin
      step();
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("rst_quiet", bad, 0);
    chk("rst_no_frames", q_data.size(), 0);
    chk("rst_no_done", done_cnt - dc0, 0);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0
    clear_q();
    tx_data = 8'h07; tx_valid = 1'b1;
    step();
    tx_data = 8'h03;
    step();
    tx_valid = 1'b0;
    wait_frames(2, 2 * FL + 10);
    frame_ok(0, 8'h07);
    frame_ok(1, 8'h03);
    chk("par_07", q_par[0], 1);
    chk("par_03", q_par[1], 0);
    chk("par_frame_len", q_start[1] - q_start[0], 11 * TK);
    step();
    chk("par_busy_drop", tx_busy, 0);
`endif

    chk("done_placement", done_err, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter paired with uart_rx. It serialises bytes onto tx_serial as 8N1 frames: start bit 0, 8 data bits LSB first, stop bit 1. It runs on the same 100 MHz fabric clock. A small input FIFO decouples the byte producer (LiDAR packet formatter / host command path) from the line rate, and queued bytes go out back-to-back with no idle gap.

Parameters:
CLK_FREQ, 100_000_000, fabric clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; BAUD_TICKS = CLK_FREQ / BAUD_RATE (integer divide, 868 at defaults)
FIFO_DEPTH, 4, input FIFO entries; power of 2, >= 2

Ports:
clk  input  1  fabric clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
tx_data  input  8  byte to transmit
tx_valid  input  1  producer offers tx_data this cycle
tx_ready  output  1  FIFO can accept; a write occurs on an edge where tx_valid && tx_ready
tx_serial  output  1  UART line, idle high, registered output
tx_busy  output  1  frame in progress (start through stop)
tx_done  output  1  one-cycle pulse on the final cycle of each stop bit
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, not yet started

Behaviour:
- Reset values: tx_serial=1, tx_busy=0, tx_done=0, fifo_count=0, FIFO empty, FSM IDLE, baud and bit counters 0. tx_ready=0 while reset is high.
- tx_ready = (fifo_count != FIFO_DEPTH) && !reset; combinational from the count register.
- A write while full is ignored; the data is dropped and the count is unchanged. Order is strict FIFO.
- FSM states and transitions:
  - IDLE -> START: on an edge where FIFO is non-empty. Pop the head into the shift register, tx_serial<=0, tx_busy<=1.
  - START -> DATA: after BAUD_TICKS cycles.
  - DATA: 8 bits, LSB first, each held exactly BAUD_TICKS cycles. Bit index counts 0..7.
  - DATA -> STOP: after the bit-7 period. tx_serial<=1.
  - STOP: held BAUD_TICKS cycles; tx_done=1 on its last cycle.
  - On leaving STOP: if FIFO non-empty, pop and go directly to START on the same edge (tx_serial 1->0, no idle cycle, tx_busy stays 1). Otherwise go to IDLE with tx_busy<=0.
- Latency: a byte written at edge N into an empty FIFO with FSM IDLE gives tx_serial=0 after edge N+1.
- Frame length is exactly 10*BAUD_TICKS cycles (8680 at defaults); every bit period is exact, with no cumulative drift.
- Baud counter: counts 0..BAUD_TICKS-1, restarts at each bit boundary. Width is $clog2(BAUD_TICKS)+1.
- Simultaneous push and pop: fifo_count unchanged, both operations take effect.
  - Full + pop: tx_ready is already low that cycle, so no push.
- Changes on tx_data/tx_valid mid-frame do not affect the frame in flight, because the shift register is loaded at pop.
- Reset mid-frame: on the next edge tx_serial=1, tx_busy=0, FIFO flushed, queued bytes discarded, no tx_done pulse.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state sits between DATA and STOP and drives even parity (XOR of the 8 data bits) for BAUD_TICKS cycles. Frame becomes 11*BAUD_TICKS cycles; all other rules are unchanged.
- Undefined: no PARITY state and no parity logic; 8N1 frames exactly as above.

Test Plan:
- Write 0x55 from idle -> tx_serial low 1 cycle after the write edge; line pattern 0,1,0,1,0,1,0,1,0,1 with each level held 868 cycles; tx_done pulses at cycle 8680 after the start edge; tx_busy then drops. Looped into uart_rx, it gives rx_data=0x55, rx_valid, no rx_error.
- Write 0xAA, 0x01, 0x02 on consecutive cycles -> three frames with no idle gap, 26040 cycles total from first start to last stop end, three tx_done pulses. uart_rx receives 0xAA, 0x01, 0x02 in order.
- During a frame in flight, hold tx_valid=1 with 0x10.. incrementing each accepted write -> exactly 4 writes accepted, fifo_count=4, tx_ready=0. Later writes are dropped. Transmitted order is 0x10..0x13.
- Assert reset for 1 cycle during data bit 3 with 2 bytes queued -> next edge: tx_serial=1, tx_busy=0, fifo_count=0, tx_ready=1. No further frames and no tx_done.
- Hold tx_valid=0 for 20000 cycles after reset -> tx_serial stays 1, tx_busy=0, no tx_done.
- With UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 (three ones in 0x07) and 0x03 -> parity bit 0 (two ones). Each frame is 9548 cycles and the stop bit follows parity.
